// File: rtl/mag_pkg.sv
// Shared types and constants for the frame-maximum reduction stage.
package mag_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } mag_state_e;

   function automatic int idx_width(input int frame_len);
      return $clog2(frame_len);
   endfunction

endpackage

// File: rtl/mag_acc_update.sv
// Running extreme update: strict compare so that ties keep the earliest sample.
// MIN_MODE=0 tracks the maximum, MIN_MODE=1 tracks the minimum.
module mag_acc_update
   import mag_pkg::*;
#(
   parameter int IDX_W    = 3,
   parameter bit MIN_MODE = 1'b0
) (
   input  logic [BYTE_W-1:0] acc_val,
   input  logic [IDX_W-1:0]  acc_idx,
   input  logic [BYTE_W-1:0] in_data,
   input  logic [IDX_W-1:0]  count,
   input  logic              first,
   output logic [BYTE_W-1:0] nxt_val,
   output logic [IDX_W-1:0]  nxt_idx
);

   logic better;

   assign better = MIN_MODE ? (in_data < acc_val) : (in_data > acc_val);

   always_comb begin
      nxt_val = acc_val;
      nxt_idx = acc_idx;
      if (first) begin
         nxt_val = in_data;
         nxt_idx = '0;
      end else if (better) begin
         nxt_val = in_data;
         nxt_idx = count;
      end
   end

endmodule

// File: rtl/mag_frame_max.sv
// Frame-maximum reduction over FRAME_LEN samples with a held, back-pressurable result.
// Optional frame-minimum tracking is enabled by defining MAG_FRAME_MIN_EN.
//
//   state    | meaning
//   ST_ACCUM | accepting samples, building the running extreme of the frame
//   ST_HOLD  | result presented; next frame's first sample taken when result consumed
module mag_frame_max
   import mag_pkg::*;
#(
   parameter int FRAME_LEN = 8,
   parameter int IDX_W     = idx_width(FRAME_LEN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [BYTE_W-1:0] out_data,
   output logic [IDX_W-1:0]  out_idx,
`ifdef MAG_FRAME_MIN_EN
   output logic [BYTE_W-1:0] out_min,
   output logic [IDX_W-1:0]  out_min_idx,
`endif
   input  logic              out_ready
);

   localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(FRAME_LEN - 1);

   mag_state_e        state_q, state_d;
   logic [IDX_W-1:0]  count_q, count_d;
   logic [BYTE_W-1:0] acc_max_q, acc_max_d;
   logic [IDX_W-1:0]  acc_idx_q, acc_idx_d;
   logic              out_valid_q, out_valid_d;
   logic [BYTE_W-1:0] out_data_q, out_data_d;
   logic [IDX_W-1:0]  out_idx_q, out_idx_d;
   logic [BYTE_W-1:0] upd_max;
   logic [IDX_W-1:0]  upd_idx;
   logic              accept;
   logic              first;
   logic              last;

   assign in_ready = (state_q == ST_ACCUM) ? 1'b1 : out_ready;
   assign accept   = in_valid && in_ready;
   assign first    = (count_q == '0);
   assign last     = (count_q == LAST_CNT);

   mag_acc_update #(.IDX_W(IDX_W), .MIN_MODE(1'b0)) u_max (
      .acc_val (acc_max_q),
      .acc_idx (acc_idx_q),
      .in_data (in_data),
      .count   (count_q),
      .first   (first),
      .nxt_val (upd_max),
      .nxt_idx (upd_idx)
   );

`ifdef MAG_FRAME_MIN_EN
   logic [BYTE_W-1:0] acc_min_q, acc_min_d;
   logic [IDX_W-1:0]  acc_min_idx_q, acc_min_idx_d;
   logic [BYTE_W-1:0] out_min_q, out_min_d;
   logic [IDX_W-1:0]  out_min_idx_q, out_min_idx_d;
   logic [BYTE_W-1:0] upd_min;
   logic [IDX_W-1:0]  upd_min_idx;

   mag_acc_update #(.IDX_W(IDX_W), .MIN_MODE(1'b1)) u_min (
      .acc_val (acc_min_q),
      .acc_idx (acc_min_idx_q),
      .in_data (in_data),
      .count   (count_q),
      .first   (first),
      .nxt_val (upd_min),
      .nxt_idx (upd_min_idx)
   );

   always_comb begin
      acc_min_d     = acc_min_q;
      acc_min_idx_d = acc_min_idx_q;
      out_min_d     = out_min_q;
      out_min_idx_d = out_min_idx_q;
      if (accept) begin
         acc_min_d     = upd_min;
         acc_min_idx_d = upd_min_idx;
         if (state_q == ST_ACCUM && last) begin
            out_min_d     = upd_min;
            out_min_idx_d = upd_min_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_min_q     <= '0;
         acc_min_idx_q <= '0;
         out_min_q     <= '0;
         out_min_idx_q <= '0;
      end else begin
         acc_min_q     <= acc_min_d;
         acc_min_idx_q <= acc_min_idx_d;
         out_min_q     <= out_min_d;
         out_min_idx_q <= out_min_idx_d;
      end
   end

   assign out_min     = out_min_q;
   assign out_min_idx = out_min_idx_q;
`endif

   // A sample taken in ST_HOLD sees count_q==0, so it always starts the new frame.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      acc_max_d   = acc_max_q;
      acc_idx_d   = acc_idx_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      if (accept) begin
         acc_max_d = upd_max;
         acc_idx_d = upd_idx;
         count_d   = count_q + IDX_W'(1);
      end
      case (state_q)
         ST_ACCUM: begin
            if (accept && last) begin
               out_data_d  = upd_max;
               out_idx_d   = upd_idx;
               out_valid_d = 1'b1;
               count_d     = '0;
               state_d     = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_ACCUM;
            end
         end
         default: state_d = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ACCUM;
         count_q     <= '0;
         acc_max_q   <= '0;
         acc_idx_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         acc_max_q   <= acc_max_d;
         acc_idx_q   <= acc_idx_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_mag_frame_max.sv
// Directed-vector bench for mag_frame_max (FRAME_LEN=8); min checks run when MAG_FRAME_MIN_EN is defined.
module tb_mag_frame_max;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic [2:0] out_idx;
   logic       out_ready;
`ifdef MAG_FRAME_MIN_EN
   logic [7:0] out_min;
   logic [2:0] out_min_idx;
`endif

   int n_vec;
   int n_err;

   mag_frame_max #(.FRAME_LEN(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_idx     (out_idx),
`ifdef MAG_FRAME_MIN_EN
      .out_min     (out_min),
      .out_min_idx (out_min_idx),
`endif
      .out_ready   (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Presents one sample and waits (bounded) until it is accepted; leaves in_valid high.
   task automatic push(input logic [7:0] d, output int waits);
      in_valid = 1'b1;
      in_data  = d;
      waits    = 0;
      while (!in_ready && waits < 20) begin
         tick();
         waits++;
      end
      if (waits >= 20) chk("accept_timeout", 32'd1, 32'd0);
      else tick();
   endtask

   task automatic check_result(input string tag, input logic [7:0] d, input logic [2:0] idx);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_data"}, {24'd0, out_data}, {24'd0, d});
      chk({tag, "_idx"}, {29'd0, out_idx}, {29'd0, idx});
   endtask

   logic [7:0] f1 [8];
   logic [7:0] f3 [8];
   int w;
   int stalls;

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = 8'h00;
      out_ready = 1'b1;
      f1 = '{8'd3, 8'd9, 8'd1, 8'd9, 8'd4, 8'd0, 8'd2, 8'd7};
      f3 = '{8'd5, 8'd2, 8'd8, 8'd2, 8'd6, 8'd1, 8'd1, 8'd3};
      tick();
      tick();
      rst = 1'b0;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {24'd0, out_data}, 32'd0);
      chk("rst_out_idx", {29'd0, out_idx}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Frame with a tie on the maximum: earlier index wins.
      for (int i = 0; i < 8; i++) begin
         push(f1[i], w);
         if (i == 6) chk("t1_no_early_valid", {31'd0, out_valid}, 32'd0);
      end
      in_valid = 1'b0;
      check_result("t1", 8'd9, 3'd1);
      tick();
      chk("t1_consumed", {31'd0, out_valid}, 32'd0);

      // Back-to-back frames with no bubble.
      stalls = 0;
      for (int i = 0; i < 8; i++) begin
         push(8'(i), w);
         stalls += w;
      end
      check_result("t2a", 8'd7, 3'd7);
      chk("t2_hold_in_ready", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         push(8'h55, w);
         stalls += w;
      end
      in_valid = 1'b0;
      check_result("t2b", 8'h55, 3'd0);
      chk("t2_stalls", 32'(stalls), 32'd0);
      tick();
      chk("t2_consumed", {31'd0, out_valid}, 32'd0);

      // Back-pressure: result held, input blocked.
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(8'(10 * (i + 1)), w);
      check_result("t3_first", 8'd80, 3'd7);
      in_valid = 1'b1;
      in_data  = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         chk("t3_in_ready_low", {31'd0, in_ready}, 32'd0);
         tick();
      end
      check_result("t3_held", 8'd80, 3'd7);
      out_ready = 1'b1;
      tick();
      chk("t3_released", {31'd0, out_valid}, 32'd0);
      for (int i = 1; i < 8; i++) push(8'(i), w);
      in_valid = 1'b0;
      check_result("t3_next", 8'hFF, 3'd0);
      tick();

      // Reset mid-frame discards partial data.
      for (int i = 0; i < 5; i++) push(8'hAA, w);
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t4_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("t4_rst_data", {24'd0, out_data}, 32'd0);
      for (int i = 0; i < 8; i++) push(8'h10, w);
      in_valid = 1'b0;
      check_result("t4", 8'h10, 3'd0);
      tick();

      // Gapped input: result only after the 8th real accept.
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b0;
         in_data  = 8'h00;
         tick();
         in_valid = 1'b1;
         in_data  = 8'hFF;
         tick();
         if (i == 6) chk("t5_no_early_valid", {31'd0, out_valid}, 32'd0);
      end
      in_valid = 1'b0;
      check_result("t5", 8'hFF, 3'd0);
      tick();

      // Mixed frame: max and (optionally) min.
      for (int i = 0; i < 8; i++) push(f3[i], w);
      in_valid = 1'b0;
      check_result("t6", 8'd8, 3'd2);
`ifdef MAG_FRAME_MIN_EN
      chk("t6_min", {24'd0, out_min}, 32'd1);
      chk("t6_min_idx", {29'd0, out_min_idx}, 32'd5);
`endif
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
